// File: rtl/ata_pkg.sv
// ata_pkg: shared definitions for the ATA PIO timing controller.
//   state_e    : access sequencer states
//   TWIDTH_DEF : default width of timing fields and phase counters
//   PIO0_*     : PIO mode-0 timing fields (cycles minus one) for a 100 MHz clock
package ata_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StRecov
  } state_e;

  localparam int unsigned TWIDTH_DEF = 8;

  localparam int unsigned PIO0_T1   = 6;
  localparam int unsigned PIO0_T2   = 28;
  localparam int unsigned PIO0_T4   = 2;
  localparam int unsigned PIO0_TEOC = 23;

endpackage

// File: rtl/ata_pio_tctrl_if.sv
// ata_pio_tctrl_if: bundles the upstream request side and the ATA device side of the
// PIO timing controller.
//   upstream : go, we, adr, d_in, T1/T2/T4/Teoc, IORDYen -> done, busy, q
//   device   : IORDY, DDi -> DDo, DDoe, DA, CS0n, CS1n, DIORn, DIOWn
// slave is the controller's view; master is the upstream/device view.
interface ata_pio_tctrl_if
  import ata_pkg::*;
#(
  parameter int unsigned TWIDTH = TWIDTH_DEF
) ();

  logic              go;
  logic              we;
  logic [3:0]        adr;
  logic [15:0]       d_in;
  logic [TWIDTH-1:0] T1;
  logic [TWIDTH-1:0] T2;
  logic [TWIDTH-1:0] T4;
  logic [TWIDTH-1:0] Teoc;
  logic              IORDYen;
  logic              IORDY;
  logic [15:0]       DDi;
  logic [15:0]       DDo;
  logic              DDoe;
  logic [2:0]        DA;
  logic              CS0n;
  logic              CS1n;
  logic              DIORn;
  logic              DIOWn;
  logic              done;
  logic              busy;
  logic [15:0]       q;

  modport slave (
    input  go, we, adr, d_in, T1, T2, T4, Teoc, IORDYen, IORDY, DDi,
    output DDo, DDoe, DA, CS0n, CS1n, DIORn, DIOWn, done, busy, q
  );

  modport master (
    output go, we, adr, d_in, T1, T2, T4, Teoc, IORDYen, IORDY, DDi,
    input  DDo, DDoe, DA, CS0n, CS1n, DIORn, DIOWn, done, busy, q
  );

endinterface

// File: rtl/ata_tcnt.sv
// ata_tcnt: loadable down-counter used to time every access phase.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   load_i, val_i : load val_i on the next edge (takes priority over counting)
//   cnt_o, zero_o : current count and its zero flag; the counter parks at zero
module ata_tcnt #(
  parameter int unsigned TWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [TWIDTH-1:0] val_i,
  output logic [TWIDTH-1:0] cnt_o,
  output logic              zero_o
);

  logic [TWIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ata_pio_tctrl.sv
// ata_pio_tctrl: ATA PIO access timing controller.
//   CLK_I  : clock
//   nReset : synchronous active-low reset
//   bus    : slave side of ata_pio_tctrl_if (request, timing fields, ATA pins, status)
// An access runs IDLE -> SETUP -> STROBE [-> WAIT] -> RECOV -> IDLE. A phase loaded with
// N lasts N+1 cycles. All outputs are registered and computed from the next state.
module ata_pio_tctrl
  import ata_pkg::*;
#(
  parameter int unsigned TWIDTH = TWIDTH_DEF
) (
  input logic            CLK_I,
  input logic            nReset,
  ata_pio_tctrl_if.slave bus
);

  state_e state_q, state_d;

  logic              we_q, we_d;
  logic [TWIDTH-1:0] t2_q, t2_d;
  logic [TWIDTH-1:0] teoc_q, teoc_d;
  // RECOV count value at which write data stops being driven
  logic [TWIDTH-1:0] thr_q, thr_d;

  logic iordy_s1_q, iordy_s2_q;

  logic [2:0]  da_q, da_d;
  logic        cs0n_q, cs0n_d;
  logic        cs1n_q, cs1n_d;
  logic        diorn_q, diorn_d;
  logic        diown_q, diown_d;
  logic [15:0] ddo_q, ddo_d;
  logic        ddoe_q, ddoe_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [15:0] q_q, q_d;

  logic              cnt_load;
  logic [TWIDTH-1:0] cnt_val;
  logic [TWIDTH-1:0] cnt;
  logic              cnt_zero;
  logic              to_recov;

  ata_tcnt #(
    .TWIDTH(TWIDTH)
  ) u_tcnt (
    .clk_i (CLK_I),
    .rst_ni(nReset),
    .load_i(cnt_load),
    .val_i (cnt_val),
    .cnt_o (cnt),
    .zero_o(cnt_zero)
  );

  // IORDY is asynchronous to CLK_I
  always_ff @(posedge CLK_I) begin
    if (!nReset) begin
      iordy_s1_q <= 1'b0;
      iordy_s2_q <= 1'b0;
    end else begin
      iordy_s1_q <= bus.IORDY;
      iordy_s2_q <= iordy_s1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    t2_d     = t2_q;
    teoc_d   = teoc_q;
    thr_d    = thr_q;
    da_d     = da_q;
    cs0n_d   = cs0n_q;
    cs1n_d   = cs1n_q;
    diorn_d  = diorn_q;
    diown_d  = diown_q;
    ddo_d    = ddo_q;
    ddoe_d   = ddoe_q;
    done_d   = 1'b0;
    q_d      = q_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    to_recov = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d  = StSetup;
          cnt_load = 1'b1;
          cnt_val  = bus.T1;
          we_d     = bus.we;
          t2_d     = bus.T2;
          teoc_d   = bus.Teoc;
          // Data is held for min(T4, Teoc)+1 RECOV cycles while counting Teoc..0
          thr_d    = (bus.T4 >= bus.Teoc) ? '0 : (bus.Teoc - bus.T4);
          da_d     = bus.adr[2:0];
          cs0n_d   = bus.adr[3];
          cs1n_d   = ~bus.adr[3];
          if (bus.we) begin
            ddo_d  = bus.d_in;
            ddoe_d = 1'b1;
          end
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d  = StStrobe;
          cnt_load = 1'b1;
          cnt_val  = t2_q;
          diorn_d  = we_q;
          diown_d  = ~we_q;
        end
      end
      StStrobe: begin
        if (cnt_zero) begin
          if (bus.IORDYen && !iordy_s2_q) begin
            state_d = StWait;
          end else begin
            to_recov = 1'b1;
          end
        end
      end
      StWait: begin
        if (iordy_s2_q) begin
          to_recov = 1'b1;
        end
      end
      StRecov: begin
        if (cnt_zero) begin
          state_d = StIdle;
          da_d    = 3'd0;
          cs0n_d  = 1'b1;
          cs1n_d  = 1'b1;
          ddoe_d  = 1'b0;
        end else if (cnt == thr_q) begin
          ddoe_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (to_recov) begin
      state_d  = StRecov;
      cnt_load = 1'b1;
      cnt_val  = teoc_q;
      diorn_d  = 1'b1;
      diown_d  = 1'b1;
      done_d   = 1'b1;
      if (!we_q) begin
        q_d = bus.DDi;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK_I) begin
    if (!nReset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      t2_q    <= '0;
      teoc_q  <= '0;
      thr_q   <= '0;
      da_q    <= 3'd0;
      cs0n_q  <= 1'b1;
      cs1n_q  <= 1'b1;
      diorn_q <= 1'b1;
      diown_q <= 1'b1;
      ddo_q   <= 16'h0000;
      ddoe_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      t2_q    <= t2_d;
      teoc_q  <= teoc_d;
      thr_q   <= thr_d;
      da_q    <= da_d;
      cs0n_q  <= cs0n_d;
      cs1n_q  <= cs1n_d;
      diorn_q <= diorn_d;
      diown_q <= diown_d;
      ddo_q   <= ddo_d;
      ddoe_q  <= ddoe_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
    end
  end

  assign bus.DA    = da_q;
  assign bus.CS0n  = cs0n_q;
  assign bus.CS1n  = cs1n_q;
  assign bus.DIORn = diorn_q;
  assign bus.DIOWn = diown_q;
  assign bus.DDo   = ddo_q;
  assign bus.DDoe  = ddoe_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_q;

endmodule

// File: tb/tb_ata_pio_tctrl.sv
// tb_ata_pio_tctrl: directed self-checking bench for ata_pio_tctrl.
module tb_ata_pio_tctrl;
  import ata_pkg::*;

  logic clk;
  logic nReset;
  int   total;
  int   bad;

  ata_pio_tctrl_if #(.TWIDTH(8)) bus ();

  ata_pio_tctrl #(
    .TWIDTH(8)
  ) dut (
    .CLK_I (clk),
    .nReset(nReset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-access measurements
  int m_busy, m_cs_sel, m_cs_oth, m_dior, m_diow, m_ddoe, m_done, m_done_rise;
  int m_inv_bad, m_da_bad, m_ddo_bad;
  logic m_timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic inv_bad_now();
    logic str_low;
    str_low = !bus.DIORn || !bus.DIOWn;
    return (!bus.DIORn && !bus.DIOWn) || (str_low && bus.CS0n && bus.CS1n);
  endfunction

  // Call with go already driven high while the DUT is idle. Runs until busy drops.
  task automatic measure(input logic [2:0] da_exp, input logic cs1_sel,
                         input logic [15:0] ddo_exp, input int go_hold,
                         input int iordy_at, input logic scramble, input int budget);
    int   n;
    int   since_done;
    int   str_idx;
    logic prev_low;
    logic str_low;
    logic sel_low;
    logic oth_low;
    m_busy = 0; m_cs_sel = 0; m_cs_oth = 0; m_dior = 0; m_diow = 0; m_ddoe = 0;
    m_done = 0; m_done_rise = 0; m_inv_bad = 0; m_da_bad = 0; m_ddo_bad = 0;
    since_done = -1;
    str_idx    = -1;
    prev_low   = 1'b0;
    tick();
    if (go_hold < 0) bus.go = 1'b0;
    if (scramble) begin
      bus.T1 = 8'd9; bus.T2 = 8'd9; bus.T4 = 8'd9; bus.Teoc = 8'd9;
    end
    n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      m_busy++;
      str_low = !bus.DIORn || !bus.DIOWn;
      sel_low = cs1_sel ? !bus.CS1n : !bus.CS0n;
      oth_low = cs1_sel ? !bus.CS0n : !bus.CS1n;
      if (sel_low) m_cs_sel++;
      if (oth_low) m_cs_oth++;
      if (sel_low && bus.DA !== da_exp) m_da_bad++;
      if (!bus.DIORn) m_dior++;
      if (!bus.DIOWn) m_diow++;
      if (bus.DDoe) begin
        m_ddoe++;
        if (bus.DDo !== ddo_exp) m_ddo_bad++;
      end
      if (inv_bad_now()) m_inv_bad++;
      if (bus.done) begin
        m_done++;
        if (prev_low && !str_low) m_done_rise++;
        since_done = 0;
      end else if (since_done >= 0) begin
        since_done++;
      end
      if (go_hold >= 0 && since_done == go_hold) bus.go = 1'b0;
      if (str_idx >= 0) str_idx++;
      else if (str_low) str_idx = 0;
      if (iordy_at > 0 && str_idx == iordy_at - 1) bus.IORDY = 1'b1;
      prev_low = str_low;
      tick();
      n++;
    end
    m_timeout = (n >= budget);
  endtask

  logic [11:0] pat;
  int          b2b_done;
  int          b2b_inv;

  initial begin
    total = 0;
    bad   = 0;
    bus.go = 1'b0; bus.we = 1'b0; bus.adr = 4'h0; bus.d_in = 16'h0000;
    bus.T1 = 8'd0; bus.T2 = 8'd0; bus.T4 = 8'd0; bus.Teoc = 8'd0;
    bus.IORDYen = 1'b0; bus.IORDY = 1'b1; bus.DDi = 16'h0000;
    nReset = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diorn", 32'(bus.DIORn), 32'd1);
    chk("rst_diown", 32'(bus.DIOWn), 32'd1);
    chk("rst_cs0n", 32'(bus.CS0n), 32'd1);
    chk("rst_cs1n", 32'(bus.CS1n), 32'd1);
    chk("rst_da", 32'(bus.DA), 32'd0);
    chk("rst_ddoe", 32'(bus.DDoe), 32'd0);
    chk("rst_ddo", 32'(bus.DDo), 32'd0);
    chk("rst_q", 32'(bus.q), 32'd0);
    nReset = 1'b1;
    tick();

    // Mode-0 read, IORDY low but extension disabled
    bus.we = 1'b0; bus.adr = 4'b0111; bus.DDi = 16'hA5C3;
    bus.T1 = 8'(PIO0_T1); bus.T2 = 8'(PIO0_T2); bus.T4 = 8'(PIO0_T4);
    bus.Teoc = 8'(PIO0_TEOC);
    bus.IORDYen = 1'b0; bus.IORDY = 1'b0;
    bus.go = 1'b1;
    measure(3'd7, 1'b0, 16'h0000, -1, -1, 1'b0, 200);
    chk("m0_timeout", 32'(m_timeout), 32'd0);
    chk("m0_busy", 32'(m_busy), 32'd60);
    chk("m0_cs0_low", 32'(m_cs_sel), 32'd60);
    chk("m0_cs1_low", 32'(m_cs_oth), 32'd0);
    chk("m0_da_bad", 32'(m_da_bad), 32'd0);
    chk("m0_dior_low", 32'(m_dior), 32'd29);
    chk("m0_diow_low", 32'(m_diow), 32'd0);
    chk("m0_ddoe", 32'(m_ddoe), 32'd0);
    chk("m0_done", 32'(m_done), 32'd1);
    chk("m0_done_rise", 32'(m_done_rise), 32'd1);
    chk("m0_inv", 32'(m_inv_bad), 32'd0);
    chk("m0_q", 32'(bus.q), 32'hA5C3);
    chk("m0_idle_cs0n", 32'(bus.CS0n), 32'd1);
    chk("m0_idle_da", 32'(bus.DA), 32'd0);
    bus.IORDY = 1'b1;

    // Short write to CS1
    bus.we = 1'b1; bus.adr = 4'b1010; bus.d_in = 16'h1234; bus.DDi = 16'hFFFF;
    bus.T1 = 8'd0; bus.T2 = 8'd2; bus.T4 = 8'd1; bus.Teoc = 8'd4;
    bus.go = 1'b1;
    measure(3'd2, 1'b1, 16'h1234, -1, -1, 1'b0, 100);
    chk("wr_timeout", 32'(m_timeout), 32'd0);
    chk("wr_busy", 32'(m_busy), 32'd9);
    chk("wr_cs1_low", 32'(m_cs_sel), 32'd9);
    chk("wr_cs0_low", 32'(m_cs_oth), 32'd0);
    chk("wr_da_bad", 32'(m_da_bad), 32'd0);
    chk("wr_diow_low", 32'(m_diow), 32'd3);
    chk("wr_dior_low", 32'(m_dior), 32'd0);
    chk("wr_ddoe", 32'(m_ddoe), 32'd6);
    chk("wr_ddo_bad", 32'(m_ddo_bad), 32'd0);
    chk("wr_done_rise", 32'(m_done_rise), 32'd1);
    chk("wr_q_held", 32'(bus.q), 32'hA5C3);
    chk("wr_idle_ddoe", 32'(bus.DDoe), 32'd0);

    // IORDY wait-state extension
    bus.we = 1'b0; bus.adr = 4'b0100; bus.DDi = 16'h0F0F;
    bus.T1 = 8'd0; bus.T2 = 8'd2; bus.T4 = 8'd0; bus.Teoc = 8'd1;
    bus.IORDYen = 1'b1; bus.IORDY = 1'b0;
    tick(); tick(); tick();
    bus.go = 1'b1;
    measure(3'd4, 1'b0, 16'h0000, -1, 10, 1'b0, 100);
    chk("rdy_timeout", 32'(m_timeout), 32'd0);
    chk("rdy_dior_low", 32'(m_dior), 32'd12);
    chk("rdy_busy", 32'(m_busy), 32'd15);
    chk("rdy_done_rise", 32'(m_done_rise), 32'd1);
    chk("rdy_q", 32'(bus.q), 32'h0F0F);
    chk("rdy_inv", 32'(m_inv_bad), 32'd0);
    bus.IORDYen = 1'b0; bus.IORDY = 1'b1;

    // go held past done, timing inputs changed mid-access
    bus.we = 1'b0; bus.adr = 4'b0001; bus.DDi = 16'h1357;
    bus.T1 = 8'd1; bus.T2 = 8'd1; bus.T4 = 8'd0; bus.Teoc = 8'd5;
    bus.go = 1'b1;
    measure(3'd1, 1'b0, 16'h0000, 2, -1, 1'b1, 100);
    chk("hold_timeout", 32'(m_timeout), 32'd0);
    chk("hold_busy", 32'(m_busy), 32'd10);
    chk("hold_dior_low", 32'(m_dior), 32'd2);
    chk("hold_done", 32'(m_done), 32'd1);
    chk("hold_q", 32'(bus.q), 32'h1357);
    tick();
    chk("hold_no_restart", 32'(bus.busy), 32'd0);
    bus.DDi = 16'h2468;
    bus.go = 1'b1;
    measure(3'd1, 1'b0, 16'h0000, -1, -1, 1'b0, 100);
    chk("new_busy", 32'(m_busy), 32'd30);
    chk("new_dior_low", 32'(m_dior), 32'd10);
    chk("new_q", 32'(bus.q), 32'h2468);

    // Reset during STROBE
    bus.we = 1'b0; bus.adr = 4'b0110; bus.DDi = 16'hFACE;
    bus.T1 = 8'd0; bus.T2 = 8'd5; bus.T4 = 8'd0; bus.Teoc = 8'd2;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    chk("rs_strobe_low", 32'(bus.DIORn), 32'd0);
    tick();
    nReset = 1'b0;
    tick();
    chk("rs_diorn", 32'(bus.DIORn), 32'd1);
    chk("rs_cs0n", 32'(bus.CS0n), 32'd1);
    chk("rs_cs1n", 32'(bus.CS1n), 32'd1);
    chk("rs_busy", 32'(bus.busy), 32'd0);
    chk("rs_done", 32'(bus.done), 32'd0);
    chk("rs_q", 32'(bus.q), 32'd0);
    nReset = 1'b1;
    tick();
    chk("rs_after_done", 32'(bus.done), 32'd0);
    chk("rs_after_busy", 32'(bus.busy), 32'd0);
    bus.we = 1'b1; bus.adr = 4'b0011; bus.d_in = 16'hBEEF;
    bus.T1 = 8'd0; bus.T2 = 8'd0; bus.T4 = 8'd0; bus.Teoc = 8'd0;
    bus.go = 1'b1;
    measure(3'd3, 1'b0, 16'hBEEF, -1, -1, 1'b0, 50);
    chk("rs_wr_busy", 32'(m_busy), 32'd3);
    chk("rs_wr_cs0_low", 32'(m_cs_sel), 32'd3);
    chk("rs_wr_diow_low", 32'(m_diow), 32'd1);
    chk("rs_wr_ddoe", 32'(m_ddoe), 32'd3);
    chk("rs_wr_ddo_bad", 32'(m_ddo_bad), 32'd0);
    chk("rs_wr_done", 32'(m_done), 32'd1);

    // Back-to-back zero-timing reads with go held high
    bus.we = 1'b0; bus.adr = 4'b1111; bus.DDi = 16'h5555;
    bus.go = 1'b1;
    pat = 12'h000;
    b2b_done = 0;
    b2b_inv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pat = {pat[10:0], bus.busy};
      if (bus.done) b2b_done++;
      if (inv_bad_now()) b2b_inv++;
    end
    bus.go = 1'b0;
    chk("b2b_pattern", 32'(pat), 32'h0EEE);
    chk("b2b_done", 32'(b2b_done), 32'd3);
    chk("b2b_inv", 32'(b2b_inv), 32'd0);
    tick(); tick(); tick(); tick();
    chk("b2b_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ata_pio_tctrl.md
ATA_PIO_TCTRL -- requirements
Module: ata_pio_tctrl

Interface
REQ-001 Parameter: TWIDTH, default 8, width of every timing field and phase counter.
REQ-002 CLK_I  in  1  single clock; all state updates on rising edge.
REQ-003 nReset  in  1  reset, synchronous and active-low.
REQ-004 go  in  1  level request from the upstream PIO register decoder; sampled only in IDLE.
REQ-005 we  in  1  1 = write access, 0 = read access; latched at acceptance.
REQ-006 adr  in  4  adr[3] = 1 selects CS1n, otherwise CS0n; adr[2:0] drives DA; latched at acceptance.
REQ-007 d_in  in  16  write data; latched at acceptance.
REQ-008 T1, T2, T4, Teoc  in  TWIDTH each  timing fields in clock cycles, minus one; latched at acceptance.
REQ-009 IORDYen  in  1  enables IORDY wait-state extension.
REQ-010 IORDY  in  1  device ready, asynchronous to CLK_I.
REQ-011 DDi  in  16  ATA data bus input.
REQ-012 DDo  out  16  ATA data bus output; DDoe  out  1  DDo output enable.
REQ-013 DA  out  3; CS0n, CS1n  out  1 each  ATA address and chip selects.
REQ-014 DIORn, DIOWn  out  1 each  ATA read and write strobes, active-low.
REQ-015 done  out  1  one-cycle pulse at strobe negation; busy  out  1  high whenever state is not IDLE.
REQ-016 q  out  16  read data captured from DDi.

Function
REQ-017 States: IDLE, SETUP, STROBE, WAIT, RECOV; every output is registered.
REQ-018 Phase lengths: a phase loaded with value N lasts N+1 cycles. Example: T1=6 gives 7 cycles.
REQ-019 IDLE->SETUP on the first edge with go=1; that edge latches we, adr, d_in, and T1/T2/T4/Teoc. Later input changes do not affect the access in flight.
REQ-020 SETUP (T1+1 cycles): DA/CSxn valid, both strobes high. On a write, DDo=d_in and DDoe=1 from the first SETUP cycle.
REQ-021 STROBE (T2+1 cycles): DIORn=0 on a read or DIOWn=0 on a write.
REQ-022 At the end of STROBE, if IORDYen=1 and synchronized IORDY=0, go to WAIT; otherwise go to RECOV.
REQ-023 WAIT: strobe stays low until synchronized IORDY=1, then go to RECOV; there is no timeout.
REQ-024 IORDY passes through a 2-flop synchronizer; its extension latency is 2 cycles.
REQ-025 On the STROBE/WAIT->RECOV edge: strobe goes high, q<=DDi (reads only; q holds its value on writes), done=1 for exactly one cycle.
REQ-026 RECOV lasts Teoc+1 cycles. DA/CSxn are held. Write DDoe stays 1 for min(T4, Teoc)+1 cycles of RECOV, then 0.
REQ-027 RECOV->IDLE. The earliest next acceptance is the edge after IDLE is entered.
REQ-028 Upstream deasserts go the cycle after done; go=1 outside IDLE is ignored.
REQ-029 In IDLE: CS0n=CS1n=1, DA=0, DDoe=0, both strobes high.
REQ-030 Zero-valued timing fields are legal and give 1-cycle phases.
REQ-031 DIORn and DIOWn are never low simultaneously; a strobe is never low with both CSxn high.

Reset
REQ-032 nReset=0 at an edge forces IDLE, DIORn=DIOWn=1, CS0n=CS1n=1, DA=0, DDoe=0, DDo=0, done=0, busy=0, q=0, and clears the synchronizer flops.
REQ-033 A reset mid-access aborts it with no done pulse; strobes go high at that edge.

Structure
REQ-034 Shared package ata_pkg holds: the state enumeration, TWIDTH default, and PIO mode-0 defaults (T1=6, T2=28, T4=2, Teoc=23 at 100 MHz).
REQ-035 One sub-module, ata_tcnt, is used for all phase timing: a loadable TWIDTH-bit down-counter with a zero flag.

Verification
REQ-036 Read, mode-0 timing, IORDYen=0, adr=4'b0111, DDi=16'hA5C3: CS0n=0 and DA=7 for 7+29+24 cycles; DIORn low exactly 29 cycles; done coincides with DIORn rising; q=16'hA5C3; busy low after 60 cycles.
REQ-037 Write, T1=0, T2=2, T4=1, Teoc=4, d_in=16'h1234, adr=4'b1010: CS1n=0, DA=2, DIOWn low 3 cycles, DDoe high 1+3+2 cycles, DDo=16'h1234 throughout.
REQ-038 IORDYen=1, IORDY low until 10 cycles after STROBE starts, T2=2: DIORn low for 10+2 cycles (synchronizer delay); done follows.
REQ-039 go held high for 2 cycles after done, T registers changed mid-access: the access keeps its latched timing; no second access starts during RECOV; a new access starts after IDLE.
REQ-040 nReset asserted during STROBE: next edge DIORn=1, CS0n=CS1n=1, busy=0, no done; a following access behaves normally.
REQ-041 Back-to-back accesses, all T=0: each access takes 3 busy cycles plus 1 IDLE cycle; REQ-031 holds throughout.
